regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port general-purpose register file for the single-cycle MIPS datapath. It replaces the fixed 32×32, two-read/one-write file with configurable width, depth and read-port count, plus a second write port (for a future load/ALU split writeback). It also adds optional write-to-read bypass and a hardware clear sequencer that zeroes every entry after reset or on request. It sits between instruction decode (read addresses) and the writeback stage (write ports).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, same packing
- we0, we1  in  1  write enables, ports 0 and 1
- wa0, wa1  in  ADDR_W  write addresses
- wd0, wd1  in  DATA_W  write data
- clr_req  in  1  single-cycle pulse; restart clear sequence
- ready  out  1  1 = file initialised; writes accepted

## Operation
- FSM states: CLEAR, READY.
- rst_n low: state = CLEAR, clear counter = 0, ready = 0. Array contents are not reset directly.
- CLEAR:
  - Each cycle write 0 to entry[counter] and increment the counter.
  - At counter = DEPTH-1, write that entry and go to READY.
  - we0/we1 are ignored.
  - All rd_data read 0.
- READY: ready = 1; normal read/write.
- clr_req in READY: go to CLEAR next edge with counter = 0.
- clr_req in CLEAR: counter restarts at 0.
- Writes (READY only): entry[waN] <= wdN when weN.
  - Both ports writing the same address: port 1 wins.
  - ZERO_REG=1: any write to address 0 is dropped.
- Reads are combinational: rd_data[i] = entry[rd_addr[i]].
  - ZERO_REG=1 and rd_addr[i]=0: read 0 regardless of array contents.
- BYPASS=1, in READY only: if rd_addr[i] matches an enabled, non-dropped write this cycle, return that write's data instead. Port 1 has priority over port 0.
- BYPASS=0: the read returns the pre-write value; the new value is visible the cycle after the edge.

## Timing
- Read latency: 0 cycles (combinational from rd_addr, the array and the write ports).
- Write latency: 1 edge.
- Clear duration: exactly DEPTH rising edges after rst_n deasserts, or after the edge that samples clr_req. ready rises on the DEPTH-th edge.
- rst_n assertion mid-clear or mid-write: ready drops immediately (async), the counter returns to 0, and any in-flight write is lost.
- Entry contents after a reset-interrupted clear are don't-care until the next full clear completes.
- clr_req and a write in the same READY cycle: the write is dropped, and CLEAR starts next edge.
- Reset value of outputs: ready = 0; rd_data = 0.

## Structure
- Package regfile_pkg holds:
  - state enum {CLEAR, READY}
  - constant REG_ZERO = 0
  - localparam helper for DEPTH
  - MIPS register index constants (r0, v0, a0, …), shared with the decoder
- Sub-module regfile_bypass: one instance per read port. Takes the array read value, both write ports, ZERO_REG/BYPASS/ready, and produces the final rd_data.
- Array: reg [DATA_W-1:0] mem [DEPTH]; the clear and write paths share one write-enable mux.

## Test plan
- Reset, hold rst_n low 3 cycles then release, defaults: ready = 0 for 32 edges, 1 after the 32nd; all reads return 0.
- READY, we0 to r5 with 0xDEADBEEF, rd_addr0 = 5 in the same cycle:
  - BYPASS=1: 0xDEADBEEF in the same cycle.
  - BYPASS=0: old value 0 that cycle, then 0xDEADBEEF the next.
- we0 (r7, 0x11111111) and we1 (r7, 0x22222222) together: r7 reads 0x22222222 afterwards; bypass also returns 0x22222222.
- Write 0xFFFFFFFF to r0 with ZERO_REG=1: r0 reads 0 before and after. With ZERO_REG=0, r0 reads 0xFFFFFFFF afterwards.
- Fill r1..r31 with nonzero values, then pulse clr_req:
  - ready = 0 next cycle, and a write issued during CLEAR is ignored.
  - After 32 edges ready = 1 and all entries read 0.
- Drop rst_n at clear count 10, release, reconfigure with NUM_RD=4, ADDR_W=3:
  - ready drops asynchronously and 8 edges are needed to reach ready.
  - All four read ports return independent correct data afterwards.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file
// and the decoder that addresses it.
package regfile_pkg;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    localparam int REG_ZERO = 0;

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    localparam int R_ZERO = 0;
    localparam int R_AT   = 1;
    localparam int R_V0   = 2;
    localparam int R_V1   = 3;
    localparam int R_A0   = 4;
    localparam int R_A1   = 5;
    localparam int R_A2   = 6;
    localparam int R_A3   = 7;
    localparam int R_T0   = 8;
    localparam int R_S0   = 16;
    localparam int R_T8   = 24;
    localparam int R_T9   = 25;
    localparam int R_K0   = 26;
    localparam int R_K1   = 27;
    localparam int R_GP   = 28;
    localparam int R_SP   = 29;
    localparam int R_FP   = 30;
    localparam int R_RA   = 31;

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/clear bundle between decode, writeback and the
// register file.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     we0;
    logic                     we1;
    logic [ADDR_W-1:0]        wa0;
    logic [ADDR_W-1:0]        wa1;
    logic [DATA_W-1:0]        wd0;
    logic [DATA_W-1:0]        wd1;
    logic                     clr_req;
    logic                     ready;

    modport master (
        output rd_addr, we0, we1, wa0, wa1, wd0, wd1, clr_req,
        input  rd_data, ready
    );

    modport slave (
        input  rd_addr, we0, we1, wa0, wa1, wd0, wd1, clr_req,
        output rd_data, ready
    );
endinterface

// File: rtl/regfile_bypass.sv
// Per-read-port output stage: zero-register masking, idle
// masking and same-cycle write forwarding.
module regfile_bypass
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              i_ready,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_mem,
    input  logic              i_we0,
    input  logic [ADDR_W-1:0] i_wa0,
    input  logic [DATA_W-1:0] i_wd0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_wa1,
    input  logic [DATA_W-1:0] i_wd1,
    output logic [DATA_W-1:0] o_data
);
    logic w_zero;
    logic w_hit0;
    logic w_hit1;

    assign w_zero = (ZERO_REG != 0) && (i_addr == ADDR_W'(REG_ZERO));
    assign w_hit0 = (BYPASS != 0) && i_we0 && (i_wa0 == i_addr);
    assign w_hit1 = (BYPASS != 0) && i_we1 && (i_wa1 == i_addr);

    // port 1 is checked first so it wins a same-address collision
    always_comb begin
        o_data = i_mem;
        if (!i_ready || w_zero) begin
            o_data = '0;
        end else if (w_hit1) begin
            o_data = i_wd1;
        end else if (w_hit0) begin
            o_data = i_wd0;
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with optional bypass
// and a clear sequencer that zeroes every entry.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = depth_of(ADDR_W);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_en  [DEPTH];
    logic [DATA_W-1:0] w_din [DEPTH];
    logic              w_ready;
    logic              w_we0;
    logic              w_we1;
    logic [DATA_W-1:0] w_rd  [NUM_RD];

    assign w_ready   = (r_state == READY);
    assign bus.ready = w_ready;

    // a write is lost while clearing, under clr_req, or aimed at r0
    assign w_we0 = bus.we0 && w_ready && !bus.clr_req &&
                   !(ZERO_REG != 0 && bus.wa0 == ADDR_W'(REG_ZERO));
    assign w_we1 = bus.we1 && w_ready && !bus.clr_req &&
                   !(ZERO_REG != 0 && bus.wa1 == ADDR_W'(REG_ZERO));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            CLEAR: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (bus.clr_req) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == ADDR_W'(DEPTH - 1)) begin
                    w_state_nxt = READY;
                    w_cnt_nxt   = '0;
                end
            end
            READY: begin
                if (bus.clr_req) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            default: ;
        endcase
    end

    // one enable/data mux per entry serves both clear and writeback
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            w_en[e]  = 1'b0;
            w_din[e] = '0;
            if (r_state == CLEAR) begin
                w_en[e] = (r_cnt == ADDR_W'(e));
            end else begin
                if (w_we0 && bus.wa0 == ADDR_W'(e)) begin
                    w_en[e]  = 1'b1;
                    w_din[e] = bus.wd0;
                end
                if (w_we1 && bus.wa1 == ADDR_W'(e)) begin
                    w_en[e]  = 1'b1;
                    w_din[e] = bus.wd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int e = 0; e < DEPTH; e++) begin
            if (w_en[e]) begin
                r_mem[e] <= w_din[e];
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        assign w_addr = bus.rd_addr[i*ADDR_W +: ADDR_W];

        regfile_bypass #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_byp (
            .i_ready (w_ready),
            .i_addr  (w_addr),
            .i_mem   (r_mem[w_addr]),
            .i_we0   (w_we0),
            .i_wa0   (bus.wa0),
            .i_wd0   (bus.wd0),
            .i_we1   (w_we1),
            .i_wa1   (bus.wa1),
            .i_wd1   (bus.wd1),
            .o_data  (w_rd[i])
        );
    end

    always_comb begin
        bus.rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            bus.rd_data[i*DATA_W +: DATA_W] = w_rd[i];
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Random and directed checks of regfile_mp in three configurations
// against an array-based reference model.
module tb_regfile_mp;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifa();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifb();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(3), .NUM_RD(4)) ifc();

    assign ifb.rd_addr = ifa.rd_addr;
    assign ifb.we0     = ifa.we0;
    assign ifb.we1     = ifa.we1;
    assign ifb.wa0     = ifa.wa0;
    assign ifb.wa1     = ifa.wa1;
    assign ifb.wd0     = ifa.wd0;
    assign ifb.wd1     = ifa.wd1;
    assign ifb.clr_req = ifa.clr_req;

    regfile_mp dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    regfile_mp #(.ZERO_REG(0), .BYPASS(0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    regfile_mp #(.ADDR_W(3), .NUM_RD(4))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    int checks = 0;
    int errors = 0;

    logic [31:0] ma [32];
    logic [31:0] mb [32];
    logic [31:0] mc [8];
    bit rdy_m, rdy_c;
    int cnt_m, cnt_c;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(
        input bit rdy, input bit zr, input bit byp, input int a,
        input bit we0, input int wa0, input logic [31:0] wd0,
        input bit we1, input int wa1, input logic [31:0] wd1,
        input bit clr, input logic [31:0] mv);
        if (!rdy) return 32'h0;
        if (zr && a == 0) return 32'h0;
        if (byp && !clr && we1 && wa1 == a) return wd1;
        if (byp && !clr && we0 && wa0 == a) return wd0;
        return mv;
    endfunction

    task automatic model_reset();
        rdy_m = 0; cnt_m = 0;
        rdy_c = 0; cnt_c = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (rdy_m) begin
                if (ifa.clr_req) begin
                    rdy_m = 0; cnt_m = 0;
                end else begin
                    if (ifa.we0) begin
                        if (ifa.wa0 != 0) ma[ifa.wa0] = ifa.wd0;
                        mb[ifa.wa0] = ifa.wd0;
                    end
                    if (ifa.we1) begin
                        if (ifa.wa1 != 0) ma[ifa.wa1] = ifa.wd1;
                        mb[ifa.wa1] = ifa.wd1;
                    end
                end
            end else if (ifa.clr_req) begin
                cnt_m = 0;
            end else begin
                cnt_m++;
                if (cnt_m == 32) begin
                    rdy_m = 1;
                    for (int k = 0; k < 32; k++) begin
                        ma[k] = 0; mb[k] = 0;
                    end
                end
            end
            if (rdy_c) begin
                if (ifc.clr_req) begin
                    rdy_c = 0; cnt_c = 0;
                end else begin
                    if (ifc.we0 && ifc.wa0 != 0) mc[ifc.wa0] = ifc.wd0;
                    if (ifc.we1 && ifc.wa1 != 0) mc[ifc.wa1] = ifc.wd1;
                end
            end else if (ifc.clr_req) begin
                cnt_c = 0;
            end else begin
                cnt_c++;
                if (cnt_c == 8) begin
                    rdy_c = 1;
                    for (int k = 0; k < 8; k++) mc[k] = 0;
                end
            end
        end
        #1;
    endtask

    task automatic check_all();
        int a;
        for (int i = 0; i < 2; i++) begin
            a = int'(ifa.rd_addr[i*5 +: 5]);
            check("rd_a", ifa.rd_data[i*32 +: 32],
                  exp_rd(rdy_m, 1, 1, a, ifa.we0, int'(ifa.wa0), ifa.wd0,
                         ifa.we1, int'(ifa.wa1), ifa.wd1, ifa.clr_req, ma[a]));
            check("rd_b", ifb.rd_data[i*32 +: 32],
                  exp_rd(rdy_m, 0, 0, a, ifa.we0, int'(ifa.wa0), ifa.wd0,
                         ifa.we1, int'(ifa.wa1), ifa.wd1, ifa.clr_req, mb[a]));
        end
        for (int i = 0; i < 4; i++) begin
            a = int'(ifc.rd_addr[i*3 +: 3]);
            check("rd_c", ifc.rd_data[i*32 +: 32],
                  exp_rd(rdy_c, 1, 1, a, ifc.we0, int'(ifc.wa0), ifc.wd0,
                         ifc.we1, int'(ifc.wa1), ifc.wd1, ifc.clr_req, mc[a]));
        end
        check("rdy_a", 32'(ifa.ready), 32'(rdy_m));
        check("rdy_b", 32'(ifb.ready), 32'(rdy_m));
        check("rdy_c", 32'(ifc.ready), 32'(rdy_c));
    endtask

    task automatic rand_ops();
        ifa.rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
        ifa.we0 = 1'($urandom_range(0, 1));
        ifa.we1 = 1'($urandom_range(0, 1));
        ifa.wa0 = 5'($urandom_range(0, 7));
        ifa.wa1 = 5'($urandom_range(0, 7));
        ifa.wd0 = $urandom;
        ifa.wd1 = $urandom;
        ifc.rd_addr = 12'($urandom);
        ifc.we0 = 1'($urandom_range(0, 1));
        ifc.we1 = 1'($urandom_range(0, 1));
        ifc.wa0 = 3'($urandom);
        ifc.wa1 = 3'($urandom);
        ifc.wd0 = $urandom;
        ifc.wd1 = $urandom;
    endtask

    task automatic cycle();
        #1;
        check_all();
        tick();
    endtask

    initial begin
        ifa.rd_addr = '0; ifa.we0 = 0; ifa.we1 = 0;
        ifa.wa0 = '0; ifa.wa1 = '0; ifa.wd0 = '0; ifa.wd1 = '0;
        ifa.clr_req = 0;
        ifc.rd_addr = '0; ifc.we0 = 0; ifc.we1 = 0;
        ifc.wa0 = '0; ifc.wa1 = '0; ifc.wd0 = '0; ifc.wd1 = '0;
        ifc.clr_req = 0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", 32'(ifa.ready), 32'h0);
        check("rst_rd", ifa.rd_data[31:0], 32'h0);
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            ifa.rd_addr = 10'($urandom);
            #1;
            check_all();
            tick();
            check("init_rdy", 32'(ifa.ready), 32'(k == 32));
        end

        // same-cycle write/read of r5
        ifa.rd_addr = {5'd0, 5'd5};
        ifa.we0 = 1; ifa.wa0 = 5'd5; ifa.wd0 = 32'hDEADBEEF;
        #1;
        check("byp_a", ifa.rd_data[31:0], 32'hDEADBEEF);
        check("nobyp_b", ifb.rd_data[31:0], 32'h0);
        check_all();
        tick();
        ifa.we0 = 0;
        #1;
        check("late_b", ifb.rd_data[31:0], 32'hDEADBEEF);
        check_all();

        // both ports target r7
        ifa.rd_addr = {5'd7, 5'd7};
        ifa.we0 = 1; ifa.wa0 = 5'd7; ifa.wd0 = 32'h11111111;
        ifa.we1 = 1; ifa.wa1 = 5'd7; ifa.wd1 = 32'h22222222;
        #1;
        check("coll_byp", ifa.rd_data[63:32], 32'h22222222);
        check_all();
        tick();
        ifa.we0 = 0; ifa.we1 = 0;
        #1;
        check("coll_a", ifa.rd_data[31:0], 32'h22222222);
        check("coll_b", ifb.rd_data[31:0], 32'h22222222);

        // r0 handling
        ifa.rd_addr = '0;
        ifa.we0 = 1; ifa.wa0 = 5'd0; ifa.wd0 = 32'hFFFFFFFF;
        #1;
        check("r0_pre_a", ifa.rd_data[31:0], 32'h0);
        check_all();
        tick();
        ifa.we0 = 0;
        #1;
        check("r0_a", ifa.rd_data[31:0], 32'h0);
        check("r0_b", ifb.rd_data[31:0], 32'hFFFFFFFF);

        for (int n = 0; n < 200; n++) begin
            rand_ops();
            cycle();
        end

        ifa.we1 = 0; ifc.we0 = 0; ifc.we1 = 0;
        for (int r = 1; r < 32; r++) begin
            ifa.we0 = 1; ifa.wa0 = 5'(r);
            ifa.wd0 = (32'(r) * 32'h01010101) | 32'h1;
            ifa.rd_addr = {5'(r), 5'(r - 1)};
            cycle();
        end
        ifa.we0 = 0;

        ifa.clr_req = 1;
        cycle();
        ifa.clr_req = 0;
        ifa.we0 = 1; ifa.wa0 = 5'd9; ifa.wd0 = 32'h55555555;
        ifa.rd_addr = {5'd9, 5'd9};
        #1;
        check("clr_rdy", 32'(ifa.ready), 32'h0);
        check("clr_rd", ifa.rd_data[31:0], 32'h0);
        check_all();
        tick();
        ifa.we0 = 0;
        for (int k = 2; k <= 32; k++) begin
            cycle();
            check("clr_done", 32'(ifa.ready), 32'(k == 32));
        end
        for (int r = 0; r < 32; r++) begin
            ifa.rd_addr = {5'(31 - r), 5'(r)};
            #1;
            check("swp0", ifa.rd_data[31:0], 32'h0);
            check("swp1", ifb.rd_data[63:32], 32'h0);
            check_all();
        end

        // interrupt a clear with reset at count 10
        for (int n = 0; n < 40; n++) begin
            rand_ops();
            cycle();
        end
        ifa.we0 = 0; ifa.we1 = 0;
        ifa.clr_req = 1;
        cycle();
        ifa.clr_req = 0;
        repeat (10) cycle();
        check("pre_rst_c", 32'(ifc.ready), 32'h1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_a", 32'(ifa.ready), 32'h0);
        check("arst_c", 32'(ifc.ready), 32'h0);
        check_all();
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            check("c_rdy", 32'(ifc.ready), 32'(k == 8));
        end
        for (int n = 0; n < 300; n++) begin
            rand_ops();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
